op_executor: RTL and testbench
==============================

OP_EXECUTOR -- requirements
Module: op_executor

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 A  input  32  operand A, sampled only at the accept edge.
REQ-005 B  input  32  operand B, sampled only at the accept edge.
REQ-006 op  input  5  operation code: 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 shl, 7 shr, 8 mul; all other codes are illegal.
REQ-007 in_valid  input  1  the source presents A, B and op.
REQ-008 in_ready  output  1  the block can accept a request.
REQ-009 result  output  32  computed value, valid while out_valid is high.
REQ-010 carry  output  1  carry out for add, borrow for sub, 0 for all other ops.
REQ-011 err  output  1  the accepted op was illegal.
REQ-012 out_valid  output  1  result, carry and err are valid.
REQ-013 out_ready  input  1  the sink takes the result.
REQ-014 busy  output  1  the block is in state EXEC.

Function
REQ-015 States are IDLE, EXEC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==EXEC).
REQ-016 Accept edge N occurs when in_valid && in_ready; at N the block latches A, B and op, loads cnt, and enters EXEC.
REQ-017 cnt load values: ops 1-5 and illegal ops load 0; op 6/7 load B[4:0]; op 8 loads 32.
REQ-018 EXEC, each edge: if cnt==0, go to DONE; otherwise perform one iteration step and decrement cnt.
REQ-019 Ops 1-5: result is computed combinationally from the latched operands and registered on the EXEC->DONE edge; out_valid is first high after edge N+1.
REQ-020 Add/sub: 33-bit unsigned arithmetic; result = low 32 bits; carry = bit 32 (for sub, borrow = A<B).
REQ-021 Op 6 shl / op 7 shr: shift by one bit per step, logical, zero-fill; the shift amount is k = B[4:0]; out_valid is first high after edge N+1+k; k=0 returns A.
REQ-022 Op 8 mul: shift-add, one multiplier bit per step; the accumulator is 32 bits and overflow is discarded; result = (A*B) mod 2^32; out_valid is first high after edge N+33.
REQ-023 Illegal op: result=0, carry=0, err=1; out_valid is first high after edge N+1.
REQ-024 DONE holds result, carry and err stable until out_valid && out_ready, then returns to IDLE on that edge.
REQ-025 There is no bypass: in_ready is low in the DONE cycle that sees out_ready, and a new accept is possible at the earliest on the following edge.
REQ-026 A, B, op and in_valid are ignored outside IDLE; input changes during EXEC or DONE do not affect the result.
REQ-027 out_ready is ignored outside DONE.
REQ-028 err and carry are cleared on every accept.

Reset
REQ-029 When reset is high at an edge: state=IDLE, result=0, carry=0, err=0, out_valid=0, busy=0, cnt=0, and all operand registers are 0.
REQ-030 In the cycle after a reset edge, in_ready=1.
REQ-031 Reset takes priority over any accept, iteration or handshake in the same cycle.
REQ-032 Reset mid-EXEC or in DONE aborts the operation, discards the result, and produces no out_valid pulse.

Verification
REQ-033 A=5, B=20, op=1, out_ready=1 -> out_valid after N+1, result=25, carry=0, err=0; then in_ready=1 one cycle later.
REQ-034 A=10, B=2, op=2 -> result=8, carry=0; A=2, B=10, op=2 -> result=0xFFFFFFF8, carry=1.
REQ-035 A=8, B=1, op=6 -> result=16 after N+2; A=0x80000000, B=31, op=7 -> result=1 after N+32, with busy high for 32 cycles.
REQ-036 A=14, B=98, op=8 -> result=1372 after N+33; A=0xFFFFFFFF, B=2 -> result=0xFFFFFFFE.
REQ-037 op=0, and separately op=9 -> err=1, result=0 after N+1; out_ready held low 5 cycles -> out_valid, result and err stay stable and in_ready stays 0 until out_ready=1.
REQ-038 Reset asserted 10 cycles into op=8 -> next cycle out_valid=0, result=0, in_ready=1; a following A=15, B=11, op=3 -> result=11.

Source files
------------

// File: rtl/op_executor.sv
// op_executor: multi-cycle ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   A, B, op            - operands and operation code, captured when in_valid && in_ready
//   in_valid, in_ready  - request handshake (in_ready high only in IDLE)
//   result, carry, err  - outputs, valid while out_valid is high
//   out_valid, out_ready- response handshake (out_valid high only in DONE)
//   busy                - high while iterating in EXEC
module op_executor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, acc, res_nx;
    logic [WIDTH:0]   sum;
    logic [4:0]       op_r;
    logic [5:0]       cnt;
    logic             accept, illegal;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state == EXEC;
    assign accept    = in_valid && in_ready;
    assign illegal   = op_r == 5'd0 || op_r > 5'd8;
    // bit WIDTH is the carry for add and the borrow (A<B) for sub
    assign sum = op_r == 5'd2 ? {1'b0, a_r} - {1'b0, b_r} : {1'b0, a_r} + {1'b0, b_r};
    always_comb begin
        res_nx = (op_r == 5'd1 || op_r == 5'd2) ? sum[WIDTH-1:0] :
                 op_r == 5'd3 ? a_r & b_r :
                 op_r == 5'd4 ? a_r | b_r :
                 op_r == 5'd5 ? a_r ^ b_r :
                 (op_r == 5'd6 || op_r == 5'd7) ? a_r :
                 op_r == 5'd8 ? acc : '0;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? EXEC : IDLE;
            EXEC:    state_nx = cnt == 6'd0 ? DONE : EXEC;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            op_r   <= '0;
            cnt    <= '0;
            result <= '0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else if (accept) begin
            a_r   <= A;
            b_r   <= B;
            op_r  <= op;
            acc   <= '0;
            carry <= 1'b0;
            err   <= 1'b0;
            cnt   <= op == 5'd8 ? 6'd32 : (op == 5'd6 || op == 5'd7) ? {1'b0, B[4:0]} : 6'd0;
        end else if (state == EXEC) begin
            if (cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
                // shifts move a_r one bit per step; mul adds A<<i when bit i of B is set
                if (op_r == 5'd6 || op_r == 5'd8) a_r <= a_r << 1;
                if (op_r == 5'd7) a_r <= a_r >> 1;
                if (op_r == 5'd8) begin
                    acc <= acc + (b_r[0] ? a_r : '0);
                    b_r <= b_r >> 1;
                end
            end else begin
                result <= res_nx;
                carry  <= (op_r == 5'd1 || op_r == 5'd2) ? sum[WIDTH] : 1'b0;
                err    <= illegal;
            end
        end
    end
endmodule

// File: tb/tb_op_executor.sv
// tb_op_executor: directed vector table plus stall and reset-abort sequences for op_executor.
module tb_op_executor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0, B = '0, result;
    logic [4:0]  op = '0;
    logic        in_valid = 1'b0, in_ready, carry, err, out_valid, out_ready = 1'b1, busy;
    int n_checks = 0, n_fail = 0;

    typedef struct {
        logic [31:0] a, b;
        logic [4:0]  op;
        logic [31:0] res;
        logic        c, e;
        int          lat;
    } vec_t;
    vec_t vecs[17];

    always #5 clk = ~clk;

    op_executor #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .in_valid(in_valid),
        .in_ready(in_ready), .result(result), .carry(carry), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int lat = 0, bsy = 0;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        A = v.a; B = v.b; op = v.op; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, " in_ready before"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; A = $urandom; B = $urandom; op = 5'($urandom);
        while (!out_valid && lat < 100) begin
            if (busy) bsy++;
            @(posedge clk);
            @(negedge clk);
            lat++;
            A = $urandom; B = $urandom; op = 5'($urandom);
        end
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " busy cycles"}, bsy, v.lat);
        chk({tag, " result"}, result, v.res);
        chk({tag, " carry"}, carry, v.c);
        chk({tag, " err"}, err, v.e);
        @(negedge clk);
        chk({tag, " in_ready after"}, in_ready, 1);
        chk({tag, " out_valid after"}, out_valid, 0);
    endtask

    initial begin
        int cyc;
        logic seen;
        vecs[0]  = '{32'd5, 32'd20, 5'd1, 32'd25, 1'b0, 1'b0, 1};
        vecs[1]  = '{32'd10, 32'd2, 5'd2, 32'd8, 1'b0, 1'b0, 1};
        vecs[2]  = '{32'd2, 32'd10, 5'd2, 32'hFFFFFFF8, 1'b1, 1'b0, 1};
        vecs[3]  = '{32'd15, 32'd11, 5'd3, 32'd11, 1'b0, 1'b0, 1};
        vecs[4]  = '{32'hF0, 32'h3C, 5'd4, 32'hFC, 1'b0, 1'b0, 1};
        vecs[5]  = '{32'hF0, 32'h3C, 5'd5, 32'hCC, 1'b0, 1'b0, 1};
        vecs[6]  = '{32'd8, 32'd1, 5'd6, 32'd16, 1'b0, 1'b0, 2};
        vecs[7]  = '{32'h80000000, 32'd31, 5'd7, 32'd1, 1'b0, 1'b0, 32};
        vecs[8]  = '{32'd14, 32'd98, 5'd8, 32'd1372, 1'b0, 1'b0, 33};
        vecs[9]  = '{32'hFFFFFFFF, 32'd2, 5'd8, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
        vecs[10] = '{32'd7, 32'd3, 5'd0, 32'd0, 1'b0, 1'b1, 1};
        vecs[11] = '{32'd7, 32'd3, 5'd9, 32'd0, 1'b0, 1'b1, 1};
        vecs[12] = '{32'hFFFFFFFF, 32'd1, 5'd1, 32'd0, 1'b1, 1'b0, 1};
        vecs[13] = '{32'd3, 32'h25, 5'd6, 32'd96, 1'b0, 1'b0, 6};
        vecs[14] = '{32'd7, 32'h20, 5'd6, 32'd7, 1'b0, 1'b0, 1};
        vecs[15] = '{32'd5, 32'd5, 5'd2, 32'd0, 1'b0, 1'b0, 1};
        vecs[16] = '{32'd1, 32'd1, 5'd31, 32'd0, 1'b0, 1'b1, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset result", result, 0);
        chk("reset carry", carry, 0);
        chk("reset err", err, 0);

        for (int i = 0; i < 17; i++) run(vecs[i], i);

        // stalled DONE: outputs hold and new requests are ignored until out_ready
        @(negedge clk);
        A = 32'd4; B = 32'd4; op = 5'd9; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        A = 32'd1; B = 32'd1; op = 5'd1;
        @(posedge clk);
        @(negedge clk);
        chk("stall out_valid first", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall out_valid", out_valid, 1);
            chk("stall result", result, 0);
            chk("stall err", err, 1);
            chk("stall in_ready", in_ready, 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("stall release in_ready", in_ready, 1);
        chk("stall release out_valid", out_valid, 0);

        // reset ten cycles into a multiply aborts it
        A = 32'hFFFF; B = 32'hFFFF; op = 5'd8; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort result", result, 0);
        chk("abort in_ready", in_ready, 1);
        chk("abort busy", busy, 0);
        seen = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort no out_valid pulse", seen, 0);
        run(vecs[3], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
